instr_fetch_ctrl: RTL and testbench
===================================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, meaning instruction-memory address width.
REQ-002 SHALL have parameter IW, default 17, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded at reset.
REQ-004 SHALL have parameter HALT_OPC, default 5'h1F, meaning the opcode value (instruction bits [16:12]) that halts fetch.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, a pulse that begins or resumes fetching.
REQ-008 SHALL have port imem_addr, output, AW, the address to the combinational instruction memory.
REQ-009 SHALL have port imem_instr, input, IW, the instruction read at imem_addr in the same cycle.
REQ-010 SHALL have port redirect, input, 1, a branch/jump taken pulse.
REQ-011 SHALL have port redirect_pc, input, AW, the target for redirect.
REQ-012 SHALL have port ir, output, IW, the fetched instruction to decode.
REQ-013 SHALL have port ir_pc, output, AW, the address of ir.
REQ-014 SHALL have port ir_valid, output, 1, meaning ir holds a valid instruction.
REQ-015 SHALL have port ir_ready, input, 1, meaning decode accepts ir this cycle.
REQ-016 SHALL have port halted, output, 1, which is high in HALT.

Function
REQ-017 SHALL implement states IDLE, RUN, STALL and HALT.
REQ-018 SHALL drive imem_addr = pc combinationally in every state.
REQ-019 SHALL move IDLE->RUN on start; start in RUN or STALL has no effect.
REQ-020 SHALL fetch in RUN when the slot is free (!ir_valid, or ir_valid&&ir_ready): ir<=imem_instr, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
REQ-021 SHALL produce one-cycle fetch latency: pc presented in cycle N gives ir_valid in cycle N+1, at a sustained throughput of 1 instruction/cycle with ir_ready=1.
REQ-022 SHALL wrap pc modulo 2^AW: 8'hFF+1 = 8'h00, with no flag.
REQ-023 SHALL enter STALL when ir_valid&&!ir_ready; ir, ir_pc and pc are held; it returns to RUN and fetches in the cycle ir_ready is high.
REQ-024 SHALL, on redirect in RUN or STALL: pc<=redirect_pc, ir_valid<=0 (flush), state<=RUN; redirect has priority over fetch and stall.
REQ-025 SHALL ignore redirect in IDLE and HALT.
REQ-026 SHALL, when a captured imem_instr[16:12]==HALT_OPC, deliver the instruction normally, leave pc at halt address+1, and go to HALT; no further fetch occurs.
REQ-027 SHALL let HALT hold ir_valid until accepted by ir_ready, then ir_valid<=0.
REQ-028 SHALL move HALT->RUN on start, resuming at pc, with halted<=0.
REQ-029 SHALL, when redirect coincides with a HALT_OPC fetch, apply redirect; the halt instruction is not captured.

Reset
REQ-030 SHALL, with rst high at a clk edge: pc<=RESET_PC, state<=IDLE, ir<=0, ir_pc<=0, ir_valid<=0, halted<=0.
REQ-031 SHALL give rst priority over start, redirect and ir_ready, including mid-stall and mid-halt.

Configuration
REQ-032 SHALL, with IFETCH_PERF_CNT_EN defined, add output fetch_count[15:0]; it increments on each REQ-020 fetch, wraps at 16'hFFFF, resets to 0, and is not cleared by redirect.
REQ-033 SHALL, without IFETCH_PERF_CNT_EN, have neither the port nor the counter.

Structure
REQ-034 SHALL place state encoding (2-bit enum), HALT_OPC default, and opcode field bounds [16:12] in shared package cpu_pkg.
REQ-035 SHALL keep the pc register plus next-pc mux in one natural sub-module pc_reg; everything else is flat.

Verification
REQ-036 SHALL cover: reset, start, ir_ready=1, memory holds 0..4 at addresses 0..4 -> ir_valid from cycle 2, ir_pc 0,1,2,3,4 on consecutive cycles.
REQ-037 SHALL cover: ir_ready=0 for 3 cycles while ir_pc=2 -> ir and pc stable, state STALL; ir_ready=1 -> ir_pc=3 next cycle.
REQ-038 SHALL cover: redirect with redirect_pc=8'h40 while ir_pc=5 -> ir_valid=0 next cycle, then ir_pc=8'h40.
REQ-039 SHALL cover: HALT_OPC instruction at 8'h06 -> delivered with ir_pc=6, halted=1, imem_addr=8'h07 frozen; start -> fetch resumes at 8'h07.
REQ-040 SHALL cover: redirect to 8'hFE with ir_ready=1 -> ir_pc FE, FF, 00 (wrap).
REQ-041 SHALL cover: rst asserted during STALL -> all outputs at reset values next cycle; with IFETCH_PERF_CNT_EN, fetch_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-controller definitions: state encoding, halt opcode, opcode field.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [4:0] HALT_OPC_DEF = 5'h1F;
    localparam int         OPC_HI       = 16;
    localparam int         OPC_LO       = 12;

endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect/increment next-pc mux; wraps modulo 2^AW.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          redirect_i,
    input  logic [AW-1:0] redirect_pc_i,
    input  logic          advance_i,
    output logic [AW-1:0] pc_o
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: single-entry IR slot, stall, redirect, halt.
// Optional fetch counter port enabled by IFETCH_PERF_CNT_EN.
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            IW       = 17,
    parameter logic [AW-1:0] RESET_PC = 8'h00,
    parameter logic [4:0]    HALT_OPC = HALT_OPC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_instr,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic [IW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic          halted
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]   fetch_count
`endif
);

    fetch_state_e  state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;

    logic [AW-1:0] pc;
    logic          active;
    logic          slot_free;
    logic          do_redirect;
    logic          do_fetch;
    logic          opc_halt;

    assign active      = (state_q == RUN) || (state_q == STALL);
    assign slot_free   = !ir_valid_q || ir_ready;
    assign do_redirect = active && redirect;
    assign do_fetch    = active && !redirect && slot_free;
    assign opc_halt    = imem_instr[OPC_HI:OPC_LO] == HALT_OPC;

    pc_reg #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (do_redirect),
        .redirect_pc_i (redirect_pc),
        .advance_i     (do_fetch),
        .pc_o          (pc)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN, STALL: begin
                if (do_redirect) begin
                    ir_valid_d = 1'b0;
                    state_d    = RUN;
                end else if (do_fetch) begin
                    ir_d       = imem_instr;
                    ir_pc_d    = pc;
                    ir_valid_d = 1'b1;
                    state_d    = opc_halt ? HALT : RUN;
                end else begin
                    state_d = STALL;
                end
            end
            HALT: begin
                // The halt instruction itself still drains to decode.
                if (ir_ready) ir_valid_d = 1'b0;
                if (start) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else if (do_fetch) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
`endif

    assign imem_addr = pc;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = state_q == HALT;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios then random traffic.
module tb_instr_fetch_ctrl;

    localparam int AW = 8;
    localparam int IW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_instr;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [IW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          halted;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0]   fetch_count;
`endif

    logic [IW-1:0] mem [256];

    assign imem_instr = mem[imem_addr];

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .halted      (halted)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    typedef struct {
        logic [7:0]  addr;
        logic        vld;
        logic        hlt;
        logic [16:0] ir;
        logic [7:0]  irpc;
        logic [15:0] cnt;
    } st_t;

    typedef struct {
        logic [7:0]  pc;
        logic [16:0] instr;
    } item_t;

    st_t   stq[$];
    item_t expq[$];
    int    compared = 0;
    int    mismatched = 0;

    // Reference: mode 0 idle, 1 fetching, 2 halted; buffer = decode slot.
    int          m_mode;
    logic [7:0]  m_pc;
    item_t       m_buf[$];
    logic [16:0] m_ir;
    logic [7:0]  m_irpc;
    logic [15:0] m_cnt;

    function automatic void m_reset();
        m_mode = 0;
        m_pc   = 8'h00;
        m_buf.delete();
        m_ir   = '0;
        m_irpc = '0;
        m_cnt  = '0;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [7:0] rpc, input logic rdy);
        st_t   st;
        item_t it;
        rst = r;
        start = s;
        redirect = rd;
        redirect_pc = rpc;
        ir_ready = rdy;
        st.addr = m_pc;
        st.vld  = m_buf.size() != 0;
        st.hlt  = m_mode == 2;
        st.ir   = m_ir;
        st.irpc = m_irpc;
        st.cnt  = m_cnt;
        stq.push_back(st);
        if (r) begin
            m_reset();
        end else begin
            if (m_buf.size() != 0 && rdy) expq.push_back(m_buf.pop_front());
            if (m_mode != 1) begin
                if (s) m_mode = 1;
            end else if (rd) begin
                m_buf.delete();
                m_pc = rpc;
            end else if (m_buf.size() == 0) begin
                it.pc = m_pc;
                it.instr = mem[m_pc];
                m_buf.push_back(it);
                m_ir = it.instr;
                m_irpc = m_pc;
                m_pc++;
                m_cnt++;
                if (it.instr[16:12] == 5'h1F) m_mode = 2;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run_until_irpc(input logic [7:0] target, input logic rdy);
        int n;
        n = 0;
        while (!(m_buf.size() != 0 && m_irpc == target) && n < 50) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, rdy);
            n++;
        end
        compared++;
        if (n >= 50) begin
            mismatched++;
            $display("FAIL wait_irpc_%0h: timeout after %0d cycles", target, n);
        end
    endtask

    initial begin : monitor
        st_t   s;
        item_t it;
        forever begin
            @(negedge clk);
            #4;
            if (stq.size() != 0) begin
                s = stq.pop_front();
                chk("imem_addr", 32'(imem_addr), 32'(s.addr));
                chk("ir_valid", 32'(ir_valid), 32'(s.vld));
                chk("halted", 32'(halted), 32'(s.hlt));
                chk("ir", 32'(ir), 32'(s.ir));
                chk("ir_pc", 32'(ir_pc), 32'(s.irpc));
`ifdef IFETCH_PERF_CNT_EN
                chk("fetch_count", 32'(fetch_count), 32'(s.cnt));
`endif
                if (rst === 1'b0 && ir_valid === 1'b1 && ir_ready === 1'b1) begin
                    if (expq.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL handshake: got ir_pc %0h expected no delivery", ir_pc);
                    end else begin
                        it = expq.pop_front();
                        chk("hs_ir", 32'(ir), 32'(it.instr));
                        chk("hs_ir_pc", 32'(ir_pc), 32'(it.pc));
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [4:0] opc;
        rst = 1'b1;
        start = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        ir_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            opc = 5'($urandom_range(0, 30));
            mem[i] = {opc, 12'($urandom)};
        end
        for (int i = 0; i < 6; i++) mem[i] = 17'(i);
        mem[6] = {5'h1F, 12'h006};
        m_reset();
        @(negedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        run_until_irpc(8'h02, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        run_until_irpc(8'h05, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
        run_until_irpc(8'h42, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1);
        run_until_irpc(8'h05, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h10, 1'b1);
        run_until_irpc(8'h11, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h06, 1'b1);
        run_until_irpc(8'h06, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        run_until_irpc(8'h08, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'hFE, 1'b1);
        run_until_irpc(8'h01, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h20, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 256; i++) begin
            opc = ($urandom_range(0, 15) == 0) ? 5'h1F : 5'($urandom_range(0, 30));
            mem[i] = {opc, 12'($urandom)};
        end
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0,
                 8'($urandom),
                 $urandom_range(0, 9) < 7);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #6;
        chk("expq_drain", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
